// File: rtl/mem_burst_responder_if.sv
// Burst bus between an initiator (master) and the on-chip responder (slave).
interface mem_burst_responder_if #(
   parameter int MEM_DATA_BITS = 32,
   parameter int ADDR_BITS     = 25
);
   logic                     rd_burst_req;
   logic                     wr_burst_req;
   logic [9:0]               rd_burst_len;
   logic [9:0]               wr_burst_len;
   logic [ADDR_BITS-1:0]     rd_burst_addr;
   logic [ADDR_BITS-1:0]     wr_burst_addr;
   logic [MEM_DATA_BITS-1:0] wr_burst_data;
   logic                     wr_burst_data_req;
   logic                     rd_burst_data_valid;
   logic [MEM_DATA_BITS-1:0] rd_burst_data;
   logic                     rd_burst_finish;
   logic                     wr_burst_finish;

   modport master (
      output rd_burst_req, wr_burst_req, rd_burst_len, wr_burst_len,
             rd_burst_addr, wr_burst_addr, wr_burst_data,
      input  wr_burst_data_req, rd_burst_data_valid, rd_burst_data,
             rd_burst_finish, wr_burst_finish
   );

   modport slave (
      input  rd_burst_req, wr_burst_req, rd_burst_len, wr_burst_len,
             rd_burst_addr, wr_burst_addr, wr_burst_data,
      output wr_burst_data_req, rd_burst_data_valid, rd_burst_data,
             rd_burst_finish, wr_burst_finish
   );
endinterface

// File: rtl/mem_burst_responder.sv
// Burst responder: services mem_burst read/write bursts from an on-chip single-port RAM.
// The throttle input suppresses beat issue to exercise initiator flow control.
module mem_burst_responder #(
   parameter int MEM_DATA_BITS = 32,
   parameter int ADDR_BITS     = 25,
   parameter int RAM_AW        = 10
) (
   input  logic                 mem_clk,
   input  logic                 rst,
   input  logic                 throttle,
   mem_burst_responder_if.slave bus
);
   localparam int DEPTH = 1 << RAM_AW;

   typedef enum logic [2:0] {IDLE, WR_DATA, WR_LAST, RD_DATA, RD_DRAIN, RD_DONE} state_t;

   state_t                   state_reg, state_next;
   logic [9:0]               count_reg, count_next;
   logic [9:0]               len_reg, len_next;
   logic [RAM_AW-1:0]        addr_reg, addr_next;
   logic [RAM_AW-1:0]        wr_addr_reg;
   logic                     wr_pend_reg;
   logic                     rd_pend_reg;
   logic [MEM_DATA_BITS-1:0] rd_data_reg;
   logic [MEM_DATA_BITS-1:0] ram [DEPTH];
   logic                     beat_req;
   logic                     rd_issue;
   logic                     addr_hi_unused;

   // Upper burst address bits fall outside the RAM and wrap silently.
   if (ADDR_BITS > RAM_AW) begin : g_addr_hi
      assign addr_hi_unused = ^{bus.rd_burst_addr[ADDR_BITS-1:RAM_AW],
                                bus.wr_burst_addr[ADDR_BITS-1:RAM_AW]};
   end else begin : g_no_addr_hi
      assign addr_hi_unused = 1'b0;
   end

   always_comb begin
      state_next = state_reg;
      count_next = count_reg;
      len_next   = len_reg;
      addr_next  = addr_reg;
      beat_req   = 1'b0;
      rd_issue   = 1'b0;
      case (state_reg)
         IDLE: begin
            if (bus.wr_burst_req) begin
               len_next   = bus.wr_burst_len;
               addr_next  = bus.wr_burst_addr[RAM_AW-1:0];
               count_next = '0;
               state_next = (bus.wr_burst_len == '0) ? WR_LAST : WR_DATA;
            end else if (bus.rd_burst_req) begin
               len_next   = bus.rd_burst_len;
               addr_next  = bus.rd_burst_addr[RAM_AW-1:0];
               count_next = '0;
               state_next = (bus.rd_burst_len == '0) ? RD_DONE : RD_DATA;
            end
         end
         WR_DATA: begin
            if (!throttle) begin
               beat_req   = 1'b1;
               count_next = count_reg + 10'd1;
               addr_next  = addr_reg + RAM_AW'(1);
               if (count_reg + 10'd1 == len_reg) state_next = WR_LAST;
            end
         end
         WR_LAST:  state_next = IDLE;
         RD_DATA: begin
            if (!throttle) begin
               rd_issue   = 1'b1;
               count_next = count_reg + 10'd1;
               addr_next  = addr_reg + RAM_AW'(1);
               if (count_reg + 10'd1 == len_reg) state_next = RD_DRAIN;
            end
         end
         RD_DRAIN: state_next = RD_DONE;
         RD_DONE:  state_next = IDLE;
         default:  state_next = IDLE;
      endcase
   end

   always_ff @(posedge mem_clk) begin
      if (rst) begin
         state_reg   <= IDLE;
         count_reg   <= '0;
         len_reg     <= '0;
         addr_reg    <= '0;
         wr_addr_reg <= '0;
         wr_pend_reg <= 1'b0;
         rd_pend_reg <= 1'b0;
      end else begin
         state_reg   <= state_next;
         count_reg   <= count_next;
         len_reg     <= len_next;
         addr_reg    <= addr_next;
         wr_pend_reg <= beat_req;
         rd_pend_reg <= rd_issue;
         if (beat_req) wr_addr_reg <= addr_reg;
      end
   end

   // Write data arrives one cycle after its request, so the write lags by a cycle.
   always_ff @(posedge mem_clk) begin
      if (wr_pend_reg && !rst) ram[wr_addr_reg] <= bus.wr_burst_data;
   end

   always_ff @(posedge mem_clk) begin
      if (rst) rd_data_reg <= '0;
      else if (rd_issue) rd_data_reg <= ram[addr_reg];
   end

   assign bus.wr_burst_data_req   = beat_req;
   assign bus.rd_burst_data_valid = rd_pend_reg;
   assign bus.rd_burst_data       = rd_data_reg;
   assign bus.wr_burst_finish     = (state_reg == WR_LAST);
   assign bus.rd_burst_finish     = (state_reg == RD_DONE);
endmodule

// File: tb/tb_mem_burst_responder.sv
// Bench for mem_burst_responder: directed and random bursts checked every cycle
// against a counter/array model of the burst protocol, plus literal timing pins.
module tb_mem_burst_responder;
   localparam int DW    = 32;
   localparam int AW    = 25;
   localparam int RAW   = 10;
   localparam int DEPTH = 1 << RAW;

   logic mem_clk;
   logic rst;
   logic throttle;
   int   cyc = 0;
   int   tests = 0;
   int   fails = 0;
   int   thr_mode = 0;
   bit   armed = 0;

   mem_burst_responder_if #(.MEM_DATA_BITS(DW), .ADDR_BITS(AW)) bus();

   mem_burst_responder #(.MEM_DATA_BITS(DW), .ADDR_BITS(AW), .RAM_AW(RAW)) dut (
      .mem_clk (mem_clk),
      .rst     (rst),
      .throttle(throttle),
      .bus     (bus)
   );

   logic [DW-1:0] wr_buf [DEPTH];
   logic [DW-1:0] mem_m  [DEPTH];
   bit            known  [DEPTH];

   int            obs_req_cyc[$];
   int            obs_val_cyc[$];
   logic [DW-1:0] obs_val_dat[$];
   int            obs_wfin_cyc[$];
   int            obs_rfin_cyc[$];

   function automatic void chk(input string nm, input longint act, input longint exp);
      tests++;
      if (act != exp) begin
         fails++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
      end
   endfunction

   function automatic void clear_obs();
      obs_req_cyc  = {};
      obs_val_cyc  = {};
      obs_val_dat  = {};
      obs_wfin_cyc = {};
      obs_rfin_cyc = {};
   endfunction

   initial begin
      mem_clk = 1'b0;
      forever #5 mem_clk = ~mem_clk;
   end

   always @(posedge mem_clk) cyc <= cyc + 1;

   initial begin
      throttle = 1'b0;
      forever begin
         @(posedge mem_clk);
         #1;
         case (thr_mode)
            1:       throttle = ~throttle;
            2:       throttle = ($urandom_range(0, 3) == 0);
            default: throttle = 1'b0;
         endcase
      end
   end

   // Protocol model: busy/phase/remaining-beat counters and scheduled finish cycles.
   int            m_busy = 0, m_kw = 0, m_ph = 0, m_left = 0;
   int            m_ra = 0, m_vk = 0, m_wa = 0, m_wl = 0;
   int            m_wfin = -1, m_rfin = -1;
   bit            m_iss = 0;
   logic [DW-1:0] m_last = '0;

   always @(negedge mem_clk) begin
      bit e_req, e_iss;
      int idx, l;
      if (rst) begin
         if (m_busy != 0 && m_kw != 0)
            for (int k = 0; k < m_wl; k++) known[(m_wa + k) % DEPTH] = 0;
         m_busy = 0; m_ph = 0; m_left = 0; m_iss = 0;
         m_wfin = -1; m_rfin = -1; m_last = '0;
      end else if (armed) begin
         e_req = (m_ph == 1) && (m_left > 0) && !throttle;
         e_iss = (m_ph == 2) && (m_left > 0) && !throttle;
         chk("wr_data_req", bus.wr_burst_data_req, e_req);
         chk("rd_valid", bus.rd_burst_data_valid, m_iss);
         chk("wr_finish", bus.wr_burst_finish, cyc == m_wfin);
         chk("rd_finish", bus.rd_burst_finish, cyc == m_rfin);
         if (m_iss) begin
            idx = (m_ra + m_vk) % DEPTH;
            if (known[idx]) chk("rd_data", bus.rd_burst_data, mem_m[idx]);
            m_last = bus.rd_burst_data;
            m_vk++;
         end else begin
            chk("rd_data_hold", bus.rd_burst_data, m_last);
         end
         if (bus.wr_burst_data_req) obs_req_cyc.push_back(cyc);
         if (bus.rd_burst_data_valid) begin
            obs_val_cyc.push_back(cyc);
            obs_val_dat.push_back(bus.rd_burst_data);
         end
         if (bus.wr_burst_finish) obs_wfin_cyc.push_back(cyc);
         if (bus.rd_burst_finish) obs_rfin_cyc.push_back(cyc);

         m_iss = e_iss;
         if (e_req || e_iss) begin
            m_left--;
            if (m_left == 0) begin
               if (m_ph == 1) m_wfin = cyc + 1;
               else m_rfin = cyc + 2;
               m_ph = 0;
            end
         end
         if (cyc == m_wfin || cyc == m_rfin) begin
            m_busy = 0;
         end else if (m_busy == 0 && (bus.wr_burst_req || bus.rd_burst_req)) begin
            m_busy = 1;
            if (bus.wr_burst_req) begin
               m_kw = 1;
               m_wa = int'(bus.wr_burst_addr[RAW-1:0]);
               m_wl = int'(bus.wr_burst_len);
               for (int k = 0; k < m_wl; k++) begin
                  mem_m[(m_wa + k) % DEPTH] = wr_buf[k];
                  known[(m_wa + k) % DEPTH] = 1;
               end
               if (m_wl == 0) m_wfin = cyc + 1;
               else begin m_ph = 1; m_left = m_wl; end
            end else begin
               m_kw = 0;
               m_ra = int'(bus.rd_burst_addr[RAW-1:0]);
               m_vk = 0;
               l    = int'(bus.rd_burst_len);
               if (l == 0) m_rfin = cyc + 1;
               else begin m_ph = 2; m_left = l; end
            end
         end
      end
   end

   // Initiator: holds each request until its first beat/finish, supplies write data a cycle after each request.
   task automatic burst(input bit dw, input int wa, input int wl,
                        input bit dr, input int ra, input int rl, output int acc);
      int need, got, guard, beats;
      bit dq, v, wf, rf;
      @(posedge mem_clk);
      #1;
      if (dw) begin
         bus.wr_burst_req  = 1'b1;
         bus.wr_burst_addr = AW'(wa);
         bus.wr_burst_len  = 10'(wl);
      end
      if (dr) begin
         bus.rd_burst_req  = 1'b1;
         bus.rd_burst_addr = AW'(ra);
         bus.rd_burst_len  = 10'(rl);
      end
      acc = cyc;
      need = int'(dw) + int'(dr);
      got = 0; guard = 0; beats = 0;
      while (got < need && guard < 4000) begin
         @(negedge mem_clk);
         dq = bus.wr_burst_data_req;
         v  = bus.rd_burst_data_valid;
         wf = bus.wr_burst_finish;
         rf = bus.rd_burst_finish;
         @(posedge mem_clk);
         #1;
         if (dq) begin
            bus.wr_burst_req = 1'b0;
            if (beats < DEPTH) bus.wr_burst_data = wr_buf[beats];
            beats++;
         end
         if (v) bus.rd_burst_req = 1'b0;
         if (wf) begin bus.wr_burst_req = 1'b0; got++; end
         if (rf) begin bus.rd_burst_req = 1'b0; got++; end
         guard++;
      end
      chk("burst_complete", got, need);
      bus.wr_burst_req = 1'b0;
      bus.rd_burst_req = 1'b0;
      $display("[TB] burst wr=%0d addr=0x%0h len=%0d rd=%0d addr=0x%0h len=%0d accept=%0d throttle_mode=%0d",
               dw, wa, wl, dr, ra, rl, acc, thr_mode);
   endtask

   initial begin
      int acc, a, wl, rl, mism;
      bit dw, dr;
      logic [7:0] cnt;
      bus.rd_burst_req = 1'b0; bus.wr_burst_req = 1'b0;
      bus.rd_burst_len = '0;   bus.wr_burst_len = '0;
      bus.rd_burst_addr = '0;  bus.wr_burst_addr = '0;
      bus.wr_burst_data = '0;
      rst = 1'b1;
      repeat (3) @(posedge mem_clk);
      #1;
      rst = 1'b0;
      armed = 1;
      @(negedge mem_clk);
      chk("reset_data_req", bus.wr_burst_data_req, 0);
      chk("reset_valid", bus.rd_burst_data_valid, 0);
      chk("reset_rd_data", bus.rd_burst_data, 0);
      chk("reset_wr_finish", bus.wr_burst_finish, 0);
      chk("reset_rd_finish", bus.rd_burst_finish, 0);

      // Directed write then read of 1..4 at 0x10, timing pinned by hand.
      for (int k = 0; k < 4; k++) wr_buf[k] = DW'(k + 1);
      clear_obs();
      burst(1, 'h10, 4, 0, 0, 0, acc);
      chk("t1_req_count", obs_req_cyc.size(), 4);
      for (int k = 0; k < obs_req_cyc.size() && k < 4; k++) chk("t1_req_cycle", obs_req_cyc[k] - acc, k + 1);
      chk("t1_wfin_count", obs_wfin_cyc.size(), 1);
      if (obs_wfin_cyc.size() > 0) chk("t1_wfin_cycle", obs_wfin_cyc[0] - acc, 5);
      clear_obs();
      burst(0, 0, 0, 1, 'h10, 4, acc);
      chk("t2_valid_count", obs_val_cyc.size(), 4);
      for (int k = 0; k < obs_val_cyc.size() && k < 4; k++) begin
         chk("t2_valid_cycle", obs_val_cyc[k] - acc, k + 2);
         chk("t2_data", obs_val_dat[k], k + 1);
      end
      chk("t2_rfin_count", obs_rfin_cyc.size(), 1);
      if (obs_rfin_cyc.size() > 0) chk("t2_rfin_cycle", obs_rfin_cyc[0] - acc, 6);

      // Pattern loop, data {4{cnt}} continuing across iterations.
      cnt = 8'd1; a = 0;
      for (int it = 0; it < 8; it++) begin
         for (int k = 0; k < 255; k++) begin wr_buf[k] = {4{cnt}}; cnt++; end
         burst(1, a, 255, 0, 0, 0, acc);
         clear_obs();
         burst(0, 0, 0, 1, a, 255, acc);
         mism = 0;
         for (int k = 0; k < 255; k++)
            if (k >= obs_val_dat.size() || obs_val_dat[k] !== wr_buf[k]) mism++;
         chk("t3_readback_mismatches", mism, 0);
         a = (a + 255) % DEPTH;
      end

      // Address wrap at the top of the RAM.
      for (int k = 0; k < 8; k++) wr_buf[k] = $urandom;
      burst(1, 1020, 8, 0, 0, 0, acc);
      clear_obs();
      burst(0, 0, 0, 1, 0, 4, acc);
      chk("t4_low_count", obs_val_dat.size(), 4);
      for (int k = 0; k < obs_val_dat.size() && k < 4; k++) chk("t4_wrapped_data", obs_val_dat[k], wr_buf[4 + k]);
      burst(0, 0, 0, 1, 1020, 8, acc);

      // Alternate-cycle throttle on 16-beat bursts.
      thr_mode = 1;
      for (int k = 0; k < 16; k++) wr_buf[k] = $urandom;
      clear_obs();
      burst(1, 'h200, 16, 0, 0, 0, acc);
      chk("t5_req_count", obs_req_cyc.size(), 16);
      if (obs_req_cyc.size() > 0 && obs_wfin_cyc.size() > 0)
         chk("t5_wfin_after_last", obs_wfin_cyc[0] - obs_req_cyc[obs_req_cyc.size() - 1], 1);
      clear_obs();
      burst(0, 0, 0, 1, 'h200, 16, acc);
      chk("t5_valid_count", obs_val_dat.size(), 16);
      for (int k = 0; k < obs_val_dat.size() && k < 16; k++) chk("t5_data_order", obs_val_dat[k], wr_buf[k]);
      if (obs_val_cyc.size() > 0 && obs_rfin_cyc.size() > 0)
         chk("t5_rfin_after_last", obs_rfin_cyc[0] - obs_val_cyc[obs_val_cyc.size() - 1], 1);
      thr_mode = 0;

      // Zero-length bursts and simultaneous requests.
      clear_obs();
      burst(1, 'h40, 0, 0, 0, 0, acc);
      chk("t6_wlen0_reqs", obs_req_cyc.size(), 0);
      if (obs_wfin_cyc.size() > 0) chk("t6_wlen0_fin_cycle", obs_wfin_cyc[0] - acc, 1);
      clear_obs();
      burst(0, 0, 0, 1, 'h40, 0, acc);
      chk("t6_rlen0_valids", obs_val_cyc.size(), 0);
      if (obs_rfin_cyc.size() > 0) chk("t6_rlen0_fin_cycle", obs_rfin_cyc[0] - acc, 1);
      for (int k = 0; k < 3; k++) wr_buf[k] = 32'hA5A5_0000 + DW'(k);
      clear_obs();
      burst(1, 'h80, 3, 1, 'h80, 3, acc);
      if (obs_wfin_cyc.size() > 0 && obs_val_cyc.size() > 0)
         chk("t6_write_first", obs_wfin_cyc[0] < obs_val_cyc[0], 1);
      for (int k = 0; k < obs_val_dat.size() && k < 3; k++) chk("t6_rd_after_wr", obs_val_dat[k], wr_buf[k]);

      // Reset in the middle of a write burst.
      for (int k = 0; k < 16; k++) wr_buf[k] = $urandom;
      clear_obs();
      @(posedge mem_clk);
      #1;
      bus.wr_burst_req = 1'b1; bus.wr_burst_addr = AW'('h300); bus.wr_burst_len = 10'd16;
      repeat (4) @(posedge mem_clk);
      #1;
      bus.wr_burst_req = 1'b0;
      rst = 1'b1;
      @(posedge mem_clk);
      #1;
      rst = 1'b0;
      repeat (20) @(posedge mem_clk);
      chk("rst_no_wfin", obs_wfin_cyc.size(), 0);
      $display("[TB] reset mid-write at 0x300, write requests seen=%0d", obs_req_cyc.size());
      burst(0, 0, 0, 1, 'h10, 2, acc);

      // Randomized bursts under random throttle.
      for (int it = 0; it < 30; it++) begin
         thr_mode = $urandom_range(0, 2);
         dw = $urandom_range(0, 1);
         dr = dw ? ($urandom_range(0, 2) == 0) : 1'b1;
         wl = ($urandom_range(0, 7) == 0) ? 0 : $urandom_range(1, 48);
         rl = ($urandom_range(0, 7) == 0) ? 0 : $urandom_range(1, 48);
         for (int k = 0; k < wl; k++) wr_buf[k] = $urandom;
         burst(dw, $urandom_range(0, (1 << AW) - 1), wl, dr, $urandom_range(0, (1 << AW) - 1), rl, acc);
      end
      thr_mode = 0;
      repeat (4) @(posedge mem_clk);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
